// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path definitions: halfword width, RVC length decode and aligner states.
package rv_fetch_pkg;

  localparam int unsigned HwWidth = 16;

  // Low two bits of a halfword equal to this mark a 32-bit instruction.
  localparam logic [1:0] RvcLen32 = 2'b11;

  typedef enum logic [0:0] {
    StRun,
    StSkipLo
  } fetch_state_e;

endpackage

// File: rtl/hw_queue.sv
// Three-entry halfword FIFO; entry 0 is the head. Pops apply before pushes in the same cycle.
module hw_queue
  import rv_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push1,
  input  logic               push2,
  input  logic [HwWidth-1:0] push_lo,
  input  logic [HwWidth-1:0] push_hi,
  input  logic               pop1,
  input  logic               pop2,
  output logic [HwWidth-1:0] head,
  output logic [HwWidth-1:0] next,
  output logic [1:0]         count
);

  logic [HwWidth-1:0] mem_q [3];
  logic [HwWidth-1:0] mem_d [3];
  logic [1:0]         count_q, count_d;
  logic [1:0]         pop_n;
  logic [1:0]         base;

  always_comb begin
    pop_n = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    base  = count_q - pop_n;
    mem_d = mem_q;
    unique case (pop_n)
      2'd1: begin
        mem_d[0] = mem_q[1];
        mem_d[1] = mem_q[2];
        mem_d[2] = '0;
      end
      2'd2: begin
        mem_d[0] = mem_q[2];
        mem_d[1] = '0;
        mem_d[2] = '0;
      end
      default: ;
    endcase
    // Appends land right after the surviving entries.
    for (int i = 0; i < 3; i++) begin
      if ((push1 || push2) && base == 2'(i)) mem_d[i] = push_lo;
      if (push2 && (base + 2'd1) == 2'(i)) mem_d[i] = push_hi;
    end
    count_d = base + (push2 ? 2'd2 : (push1 ? 2'd1 : 2'd0));
    if (clr) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < 3; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head  = mem_q[0];
  assign next  = mem_q[1];
  assign count = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Splits 32-bit fetch words into 16/32-bit RISC-V instructions with their PCs.
// Define FETCH_ALIGNER_ILLEGAL_CHK_EN to flag the all-zero 16-bit illegal encoding.
module fetch_aligner
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c,
  input  logic        inst_ready,
  output logic        inst_illegal
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [HwWidth-1:0] head, next;
  logic [1:0]         count;
  logic               head_is32;
  logic               fire, accept;
  logic               pop1, pop2, push1, push2;
  logic [1:0]         popped;
  logic [HwWidth-1:0] push_lo;

  assign head_is32  = (head[1:0] == RvcLen32);
  assign inst_valid = ((count >= 2'd1) && !head_is32) || (count >= 2'd2);
  assign fire       = inst_valid && inst_ready && !flush;
  assign pop2       = fire && head_is32;
  assign pop1       = fire && !head_is32;
  assign popped     = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
  assign in_ready   = !flush && ((3'(count) - 3'(popped)) <= 3'd1);
  assign accept     = in_valid && in_ready;
  assign push2      = accept && (state_q == StRun);
  assign push1      = accept && (state_q == StSkipLo);
  assign push_lo    = (state_q == StSkipLo) ? in_data[31:16] : in_data[15:0];

  hw_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .push1   (push1),
    .push2   (push2),
    .push_lo (push_lo),
    .push_hi (in_data[31:16]),
    .pop1    (pop1),
    .pop2    (pop2),
    .head    (head),
    .next    (next),
    .count   (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = flush_pc[1] ? StSkipLo : StRun;
      pc_d    = {flush_pc[31:1], 1'b0};
    end else begin
      if (accept && state_q == StSkipLo) state_d = StRun;
      if (fire) pc_d = pc_q + (head_is32 ? 32'd4 : 32'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Data outputs read zero whenever no instruction is presented.
  always_comb begin
    inst      = 32'h0;
    inst_is_c = 1'b0;
    if (inst_valid) begin
      inst_is_c = !head_is32;
      inst      = head_is32 ? {next, head} : {16'h0, head};
    end
  end

  assign inst_pc = pc_q;

`ifdef FETCH_ALIGNER_ILLEGAL_CHK_EN
  assign inst_illegal = inst_valid && !head_is32 && (head == 16'h0000);
`else
  assign inst_illegal = 1'b0;
`endif

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC of the first instruction after reset; halfword-aligned.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discard buffered data and restart at flush_pc.
REQ-005 SHALL have port flush_pc  input  32  restart PC; bit 0 ignored.
REQ-006 SHALL have port in_valid  input  1  fetched word valid.
REQ-007 SHALL have port in_data  input  32  little-endian fetched word.
REQ-008 SHALL have port in_ready  output  1  aligner accepts in_data this cycle.
REQ-009 SHALL have port inst_valid  output  1  complete instruction available.
REQ-010 SHALL have port inst  output  32  instruction; 16-bit forms zero-extended.
REQ-011 SHALL have port inst_pc  output  32  PC of inst.
REQ-012 SHALL have port inst_is_c  output  1  inst is 16-bit compressed.
REQ-013 SHALL have port inst_ready  input  1  consumer takes inst this cycle.
REQ-014 SHALL have port inst_illegal  output  1  inst is the all-zero 16-bit illegal encoding.

Function
REQ-015 SHALL hold a 3-halfword FIFO buffer with occupancy count 0..3; the oldest halfword is at the head.
REQ-016 SHALL classify the head as 32-bit when head[1:0]==2'b11, else as 16-bit.
REQ-017 SHALL assert inst_valid combinationally when (count>=1 and head is 16-bit) or count>=2.
REQ-018 SHALL drive inst={16'h0,head} for 16-bit and {next,head} for 32-bit, with inst_is_c = !(head[1:0]==2'b11).
REQ-019 SHALL pop 1 or 2 halfwords on inst_valid&&inst_ready, advancing inst_pc by 2 or 4 (mod 2^32, wrap-around allowed).
REQ-020 SHALL drive in_ready = !flush && (count - popped_this_cycle) <= 1, so a pop and a push can occur in the same cycle.
REQ-021 SHALL append both halfwords on in_valid&&in_ready, low half first, except in state SKIP_LO.
REQ-022 SHALL implement states RUN and SKIP_LO: flush with flush_pc[1]==1 -> SKIP_LO; in SKIP_LO the next accepted word pushes only in_data[31:16] and moves to RUN.
REQ-023 SHALL, on flush, clear count, set inst_pc<=flush_pc with bit 0 cleared, and enter RUN when flush_pc[1]==0.
REQ-024 SHALL, on flush, ignore same-cycle input and output handshakes; flush has priority over everything except rst_n.
REQ-025 SHALL keep inst, inst_pc and inst_is_c stable while inst_valid&&!inst_ready.

Reset
REQ-026 SHALL, on rst_n low, immediately set count=0, state=RUN, inst_pc=RESET_PC, inst_valid=0, inst=0, inst_is_c=0 and inst_illegal=0; in_ready then reads 1.
REQ-027 SHALL, on reset asserted mid-operation, discard buffered halfwords with no partial output.

Configuration
REQ-028 SHALL, with macro FETCH_ALIGNER_ILLEGAL_CHK_EN defined, drive inst_illegal=1 when inst_valid and the 16-bit head==16'h0000.
REQ-029 SHALL, without FETCH_ALIGNER_ILLEGAL_CHK_EN, tie inst_illegal to 0 and omit the detection logic.

Structure
REQ-030 SHALL take halfword width, the RVC length-decode constant 2'b11 and the state enum from shared package rv_fetch_pkg.
REQ-031 SHALL place the 3-entry halfword FIFO in sub-module hw_queue, which has push-1/push-2/pop-1/pop-2 ports.

Verification
REQ-032 SHALL cover: reset, words 0x00A00093 and 0x00B00113 -> two 32-bit insts at PC 0x0 and 0x4, inst_is_c=0.
REQ-033 SHALL cover: word 0x4585_4505 -> inst 0x00004505 at PC 0x0, then 0x00004585 at PC 0x2, both inst_is_c=1.
REQ-034 SHALL cover: mixed word 0x0093_4505 then 0x0000_00A0 -> 16-bit inst 0x4505 at PC 0x0, then 32-bit inst 0x00A00093 spanning two words at PC 0x2.
REQ-035 SHALL cover: flush with flush_pc=0x0000_0102, next word 0x4505_FFFF -> low half discarded, inst 0x00004505 at PC 0x102.
REQ-036 SHALL cover: inst_ready held low for 5 cycles with count==3 -> in_ready=0 and outputs stable; flush asserted together with in_valid -> no push, count=0.
REQ-037 SHALL cover: FETCH_ALIGNER_ILLEGAL_CHK_EN defined and word 0x0000_0000 -> inst_illegal=1 at PC 0x0 and PC 0x2; undefined -> inst_illegal=0.
